iic_cam_init_sequencer: RTL

Table-driven configuration sequencer for a camera sensor on one PL IIC bus (single-cam or stereo-cam bus). On a start pulse it walks an external register table. For each write entry it issues a 4-byte IIC write (device address, register high, register low, data) through the command handshake of a byte-level IIC master. It also executes millisecond delay entries and retries NACKed transactions. One instance sits beside each camera IIC master; software only triggers it and reads status.

---
 rtl/iic_seq_pkg.sv | 47 ++++
 rtl/iic_seq_ms_tick.sv | 29 ++
 rtl/iic_cam_init_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/iic_seq_pkg.sv
// Shared types for the camera IIC init sequencer.
// Table entry layout, op codes and controller states.
package iic_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_RSP,
    S_DELAY,
    S_RETRY_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int ARG_MSB  = 23;
  localparam int ARG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Byte n of the 4-byte register write for a given entry payload.
  function automatic logic [7:0] entry_byte(
    input logic [6:0]  dev,
    input logic [23:0] ent,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = ent[ARG_MSB:ARG_MSB-7];
      2'd2:    b = ent[ARG_LSB+7:ARG_LSB];
      default: b = ent[DATA_MSB:DATA_LSB];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iic_seq_ms_tick.sv
// Free-running 1 ms prescaler.
// Emits a single-cycle tick every CLK_FREQ_HZ/1000 clocks.
module iic_seq_ms_tick #(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= CW'(DIV - 1);
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= CW'(DIV - 1);
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/iic_cam_init_sequencer.sv
// Table-driven camera sensor configuration over a byte-level IIC master.
// Walks register writes and ms delays, retrying NACKed writes.
module iic_cam_init_sequencer
  import iic_seq_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 100000000,
  parameter logic [6:0] DEV_ADDR     = 7'h3C,
  parameter int         TBL_AW       = 8,
  parameter int         MAX_RETRIES  = 3,
  parameter int         RETRY_GAP_MS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_start,
  output logic              cmd_stop,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_nack
);

  localparam int         RW  = $clog2(MAX_RETRIES + 2);
  localparam logic [15:0] GAP = 16'(RETRY_GAP_MS);

  state_e            state;
  logic [TBL_AW-1:0] index;
  logic [RW-1:0]     retry;
  logic [1:0]        byte_idx;
  logic [23:0]       entry;
  logic [15:0]       count;
  logic              tick;

  op_e         op;
  logic [15:0] arg;
  logic        last;
  logic        can_retry;
  logic        ack;
  logic        nack;
  logic        adv;
  logic        load;
  logic [1:0]  load_idx;
  logic [23:0] load_ent;
  logic        unused_bits;

  iic_seq_ms_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign op          = op_e'(tbl_data[OP_MSB:OP_LSB]);
  assign arg         = tbl_data[ARG_MSB:ARG_LSB];
  assign last        = &index;
  assign can_retry   = retry < RW'(MAX_RETRIES);
  assign ack         = rsp_valid && !rsp_nack;
  assign nack        = rsp_valid && rsp_nack;
  assign unused_bits = ^tbl_data[29:24];

  // adv moves to the next entry; load presents a byte to the master.
  always_comb begin
    adv      = 1'b0;
    load     = 1'b0;
    load_idx = 2'd0;
    load_ent = entry;
    case (state)
      S_DECODE: begin
        load_ent = tbl_data[23:0];
        load     = (op == OP_WRITE);
        adv      = (op == OP_DELAY) && (arg == 16'd0);
      end
      S_WAIT_RSP: begin
        adv      = ack && (byte_idx == 2'd3);
        load     = (ack && (byte_idx != 2'd3)) ||
                   (nack && can_retry && (GAP == 16'd0));
        load_idx = ack ? byte_idx + 2'd1 : 2'd0;
      end
      S_DELAY: begin
        adv = tick && (count <= 16'd1);
      end
      S_RETRY_WAIT: begin
        load = tick && (count <= 16'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      index     <= '0;
      retry     <= '0;
      byte_idx  <= 2'd0;
      entry     <= 24'd0;
      count     <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      tbl_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_data  <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            index     <= '0;
            retry     <= '0;
            tbl_addr  <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          entry <= tbl_data[23:0];
          if (op == OP_DELAY) begin
            count <= arg;
            state <= S_DELAY;
          end else if (op != OP_WRITE) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_SEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_start <= 1'b0;
            cmd_stop  <= 1'b0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (nack) begin
            if (can_retry) begin
              retry <= retry + 1'b1;
              count <= GAP;
              state <= S_RETRY_WAIT;
            end else begin
              err_index <= index;
              error     <= 1'b1;
              busy      <= 1'b0;
              state     <= S_ERROR;
            end
          end
        end
        S_DELAY, S_RETRY_WAIT: begin
          if (tick && (count > 16'd1)) count <= count - 16'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        retry <= '0;
        if (last) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end else begin
          index    <= index + 1'b1;
          tbl_addr <= index + 1'b1;
          state    <= S_FETCH;
        end
      end

      if (load) begin
        byte_idx  <= load_idx;
        cmd_valid <= 1'b1;
        cmd_start <= (load_idx == 2'd0);
        cmd_stop  <= (load_idx == 2'd3);
        cmd_data  <= entry_byte(DEV_ADDR, load_ent, load_idx);
        state     <= S_SEND;
      end
    end
  end

endmodule
